// File: rtl/morse_classifier.sv
// rtl/morse_classifier.sv - turns key press/release timing into Morse letters and word breaks
// Press length picks dot or dash; key-up length closes a letter, then a word.
module morse_classifier #(
   parameter int DOT_MAX    = 8,
   parameter int LETTER_GAP = 24,
   parameter int WORD_GAP   = 56,
   parameter int CNT_W      = 16
) (
   input  logic       clk,
   input  logic       clrn,
   input  logic       key,
   input  logic       key_edge,
   output logic [4:0] code,
   output logic [2:0] len,
   output logic       letter_valid,
   output logic       letter_err,
   output logic       word_gap
);

   typedef enum logic [1:0] {IDLE, PRESS, GAP} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] DOT_LIM = CNT_W'(DOT_MAX);
   localparam logic [CNT_W-1:0] LG_LIM  = CNT_W'(LETTER_GAP);
   localparam logic [CNT_W-1:0] WG_LIM  = CNT_W'(WORD_GAP);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] press_cnt_q, press_cnt_d;
   logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
   logic [4:0]       code_q, code_d;
   logic [2:0]       len_q, len_d;
   logic             ovf_q, ovf_d;
   logic             owed_q, owed_d;
   logic             letter_valid_q, letter_valid_d;
   logic             letter_err_q, letter_err_d;
   logic             word_gap_q, word_gap_d;
   logic             rise, fall;

   assign rise = key_edge & key;
   assign fall = key_edge & ~key;

   always_comb begin
      state_d        = state_q;
      press_cnt_d    = press_cnt_q;
      gap_cnt_d      = gap_cnt_q;
      code_d         = code_q;
      len_d          = len_q;
      ovf_d          = ovf_q;
      owed_d         = owed_q;
      letter_valid_d = 1'b0;
      letter_err_d   = 1'b0;
      word_gap_d     = 1'b0;

      // The letter is presented for one cycle, then the buffer empties.
      if (letter_valid_q) begin
         code_d = '0;
         len_d  = '0;
         ovf_d  = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (rise) begin
               state_d     = PRESS;
               press_cnt_d = CNT_W'(1);
            end
         end
         PRESS: begin
            if (fall) begin
               state_d   = GAP;
               gap_cnt_d = '0;
               if (len_q < 3'd5) begin
                  code_d[len_q] = (press_cnt_q > DOT_LIM);
                  len_d         = len_q + 3'd1;
               end else begin
                  ovf_d = 1'b1;
               end
            end else if (press_cnt_q != CNT_MAX) begin
               press_cnt_d = press_cnt_q + CNT_W'(1);
            end
         end
         GAP: begin
            // A rise on a threshold cycle suppresses that threshold's strobe.
            if (rise) begin
               state_d     = PRESS;
               press_cnt_d = CNT_W'(1);
            end else begin
               if (gap_cnt_q != CNT_MAX) gap_cnt_d = gap_cnt_q + CNT_W'(1);
               if (gap_cnt_q == LG_LIM && len_q != 3'd0) begin
                  letter_valid_d = 1'b1;
                  letter_err_d   = ovf_q;
                  owed_d         = 1'b1;
               end
               if (gap_cnt_q == WG_LIM) begin
                  word_gap_d = owed_q;
                  owed_d     = 1'b0;
                  state_d    = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state_q        <= IDLE;
         press_cnt_q    <= '0;
         gap_cnt_q      <= '0;
         code_q         <= '0;
         len_q          <= '0;
         ovf_q          <= 1'b0;
         owed_q         <= 1'b0;
         letter_valid_q <= 1'b0;
         letter_err_q   <= 1'b0;
         word_gap_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         press_cnt_q    <= press_cnt_d;
         gap_cnt_q      <= gap_cnt_d;
         code_q         <= code_d;
         len_q          <= len_d;
         ovf_q          <= ovf_d;
         owed_q         <= owed_d;
         letter_valid_q <= letter_valid_d;
         letter_err_q   <= letter_err_d;
         word_gap_q     <= word_gap_d;
      end
   end

   assign code         = code_q;
   assign len          = len_q;
   assign letter_valid = letter_valid_q;
   assign letter_err   = letter_err_q;
   assign word_gap     = word_gap_q;

endmodule

// File: tb/tb_morse_classifier.sv
// tb/tb_morse_classifier.sv - directed and random key sequences checked against a timing model
// The model maps (press, gap) duration lists to expected letter and word events.
module tb_morse_classifier;

   localparam int DOT_MAX    = 4;
   localparam int LETTER_GAP = 12;
   localparam int WORD_GAP   = 28;
   localparam int CNT_W      = 16;

   logic       clk = 1'b0;
   logic       clrn = 1'b0;
   logic       key = 1'b0;
   logic       key_edge = 1'b0;
   logic [4:0] code;
   logic [2:0] len;
   logic       letter_valid, letter_err, word_gap;

   int errors = 0;
   int checks = 0;

   int pr[$];
   int gp[$];
   int lv_code[int];
   int lv_len[int];
   int lv_err[int];
   bit wg_at[int];
   bit clr_at[int];

   morse_classifier #(
      .DOT_MAX(DOT_MAX), .LETTER_GAP(LETTER_GAP), .WORD_GAP(WORD_GAP), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .clrn(clrn), .key(key), .key_edge(key_edge),
      .code(code), .len(len), .letter_valid(letter_valid),
      .letter_err(letter_err), .word_gap(word_gap)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Cycle 0 is the first press cycle; a fall at cycle f yields a letter
   // visible after the edge of cycle f+LETTER_GAP+1 if the key stays up that long.
   task automatic build_model();
      int t = 0;
      int n = 0;
      int code_m = 0;
      int ovf = 0;
      int owed = 0;
      lv_code.delete(); lv_len.delete(); lv_err.delete(); wg_at.delete(); clr_at.delete();
      foreach (pr[i]) begin
         int f;
         f = t + pr[i];
         if (n < 5) begin
            if (pr[i] > DOT_MAX) code_m += (1 << n);
            n++;
         end else begin
            ovf = 1;
         end
         if (gp[i] >= LETTER_GAP + 2) begin
            lv_code[f + LETTER_GAP + 1] = code_m;
            lv_len[f + LETTER_GAP + 1]  = n;
            lv_err[f + LETTER_GAP + 1]  = ovf;
            clr_at[f + LETTER_GAP + 2]  = 1'b1;
            n = 0; code_m = 0; ovf = 0; owed = 1;
         end
         if (gp[i] >= WORD_GAP + 2 && owed == 1) begin
            wg_at[f + WORD_GAP + 1] = 1'b1;
            owed = 0;
         end
         t = f + gp[i];
      end
   endtask

   task automatic step(input logic k, input logic e, input int c);
      @(negedge clk);
      key = k;
      key_edge = e;
      @(posedge clk);
      #1;
      chk("letter_valid", letter_valid, lv_len.exists(c));
      chk("word_gap", word_gap, wg_at.exists(c));
      if (lv_len.exists(c)) begin
         chk("code", code, lv_code[c]);
         chk("len", len, lv_len[c]);
         chk("letter_err", letter_err, lv_err[c]);
      end else begin
         chk("letter_err_idle", letter_err, 0);
      end
      if (clr_at.exists(c)) begin
         chk("len_cleared", len, 0);
         chk("code_cleared", code, 0);
      end
   endtask

   // dup adds a stray fall from idle plus duplicate rise/fall pulses
   task automatic run(input bit dup);
      int c = 0;
      build_model();
      if (dup) step(1'b0, 1'b1, -1);
      foreach (pr[i]) begin
         for (int k = 0; k < pr[i]; k++) begin
            step(1'b1, (k == 0) || (dup && k == 2), c);
            c++;
         end
         for (int k = 0; k < gp[i]; k++) begin
            step(1'b0, (k == 0) || (dup && k == 3), c);
            c++;
         end
      end
      @(negedge clk);
      key_edge = 1'b0;
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_code"}, code, 0);
      chk({tag, "_len"}, len, 0);
      chk({tag, "_lv"}, letter_valid, 0);
      chk({tag, "_err"}, letter_err, 0);
      chk({tag, "_wg"}, word_gap, 0);
   endtask

   task automatic apply_reset(input string tag);
      @(negedge clk);
      key = 1'b0;
      key_edge = 1'b0;
      #2 clrn = 1'b0;
      #1 check_zero(tag);
      @(negedge clk);
      clrn = 1'b1;
      step(1'b0, 1'b0, -1);
      step(1'b0, 1'b0, -1);
   endtask

   initial begin
      int gchoice[8];
      int nsym;
      gchoice = '{2, 4, 6, 13, 14, 15, 29, 30};
      #1 check_zero("reset");
      @(negedge clk);
      clrn = 1'b1;
      step(1'b0, 1'b0, -1);

      // Single dot, 20 cycles up: letter but no word
      pr = '{3};  gp = '{20};  run(1'b0);
      apply_reset("reset_after_dot");

      // K = dash dot dash
      pr = '{10, 3, 10};  gp = '{5, 5, 40};  run(1'b0);

      // Six dots overflow
      pr = '{2, 2, 2, 2, 2, 2};  gp = '{4, 4, 4, 4, 4, 40};  run(1'b0);

      // Dot/dash boundary, separate letters
      pr = '{4, 5};  gp = '{20, 40};  run(1'b0);

      // Rise exactly on the letter threshold cycle
      pr = '{3, 6};  gp = '{LETTER_GAP + 1, 40};  run(1'b0);

      // Reset during the second symbol
      step(1'b1, 1'b1, -1);
      for (int k = 0; k < 9; k++) step(1'b1, 1'b0, -1);
      step(1'b0, 1'b1, -1);
      for (int k = 0; k < 4; k++) step(1'b0, 1'b0, -1);
      step(1'b1, 1'b1, -1);
      step(1'b1, 1'b0, -1);
      chk("pre_reset_len", len, 1);
      chk("pre_reset_code", code, 1);
      apply_reset("reset_mid_letter");
      pr = '{3, 10};  gp = '{5, 40};  run(1'b0);

      // Randomized letters with duplicate and stray edges
      for (int s = 0; s < 8; s++) begin
         pr.delete();
         gp.delete();
         nsym = $urandom_range(1, 7);
         for (int i = 0; i < nsym; i++) begin
            pr.push_back($urandom_range(1, 8));
            gp.push_back((i == nsym - 1) ? 40 : gchoice[$urandom_range(0, 7)]);
         end
         run(1'b1);
      end

      // Long press saturates rather than wrapping back to a dot
      pr = '{70000};  gp = '{40};  run(1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/morse_classifier.md
MORSE_CLASSIFIER -- requirements
Module: morse_classifier

Interface
REQ-001 Parameter DOT_MAX, default 8: longest key-press (cycles) still classified as dot.
REQ-002 Parameter LETTER_GAP, default 24: key-up cycles that close a letter.
REQ-003 Parameter WORD_GAP, default 56: key-up cycles that close a word; SHALL exceed LETTER_GAP.
REQ-004 Parameter CNT_W, default 16: width of press and gap counters.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 clrn  input  1  reset, asynchronous, active-low.
REQ-007 key  input  1  synchronised key level, 1 = pressed.
REQ-008 key_edge  input  1  one-cycle pulse from upstream edge detector on any key transition.
REQ-009 code  output  5  symbol bits, bit i = symbol i (1 = dash, 0 = dot), first symbol in bit 0.
REQ-010 len  output  3  number of valid symbols in code, 0..5.
REQ-011 letter_valid  output  1  one-cycle strobe: code/len hold a completed letter.
REQ-012 letter_err  output  1  qualifies letter_valid: more than 5 symbols were keyed.
REQ-013 word_gap  output  1  one-cycle strobe: word boundary.

Function
REQ-014 Rise event = key_edge & key; fall event = key_edge & ~key; block SHALL NOT detect edges itself.
REQ-015 States: IDLE (no pending symbols, no word owed), PRESS (key held), GAP (key released, letter or word pending).
REQ-016 IDLE -> PRESS on rise; PRESS -> GAP on fall; GAP -> PRESS on rise; GAP -> IDLE on the cycle word_gap is emitted.
REQ-017 On rise: press_cnt cleared to 1; press_cnt increments each further cycle in PRESS, saturating at 2^CNT_W-1.
REQ-018 On fall: symbol = dash if press_cnt > DOT_MAX, else dot; written to code[len], len incremented, gap_cnt cleared to 0.
REQ-019 Fall with len = 5: symbol discarded, len/code unchanged, internal overflow flag set.
REQ-020 In GAP, gap_cnt increments each cycle, saturating; no increment on the fall cycle.
REQ-021 letter_valid SHALL assert for exactly one cycle, on the cycle after gap_cnt reaches LETTER_GAP while len > 0; letter_err = overflow flag in that cycle.
REQ-022 code/len SHALL be stable while letter_valid is high; on the following cycle code, len, overflow flag clear to 0.
REQ-023 word_gap SHALL assert for exactly one cycle, on the cycle after gap_cnt reaches WORD_GAP, only if at least one letter was emitted since the last word_gap.
REQ-024 Rise in the same cycle a threshold is reached: rise wins; no strobe, pending symbols retained, state -> PRESS.
REQ-025 key_edge with key level unchanged from the previous pulse type (duplicate rise or fall) SHALL be ignored.
REQ-026 Fall in IDLE (no preceding rise) SHALL be ignored.
REQ-027 letter_err, letter_valid, word_gap SHALL be 0 outside their defined strobe cycles.

Reset
REQ-028 clrn low SHALL immediately force state IDLE, code = 0, len = 0, counters = 0, overflow flag = 0, letter_valid = 0, letter_err = 0, word_gap = 0.
REQ-029 Reset mid-press or mid-gap SHALL discard pending symbols; first event after release SHALL be a rise.
REQ-030 Deassertion SHALL take effect at the next clk edge; no strobe within 1 cycle of deassertion.

Verification (DOT_MAX=4, LETTER_GAP=12, WORD_GAP=28)
REQ-031 Press 3 cycles, release 20 -> letter_valid once, code=00000, len=1, letter_err=0; no word_gap.
REQ-032 "K": dash 10, gap 5, dot 3, gap 5, dash 10, then 40 idle -> code=00101, len=3 at letter_valid; word_gap one cycle, 16 cycles later.
REQ-033 Six dots (press 2, gap 4 each), then idle 15 -> letter_valid with len=5, code=00000, letter_err=1.
REQ-034 Press exactly 4 -> dot; exactly 5 -> dash; rise landing on the LETTER_GAP threshold cycle -> no letter_valid, len retained.
REQ-035 clrn pulled low during second symbol of a letter -> all outputs 0 immediately; next full letter after release reports only its own symbols.
REQ-036 Press held 70000 cycles with CNT_W=16 -> counter saturates, classified dash, no wrap to dot.
